aurora_pkt_io_block: RTL
========================

// Module: aurora_pkt_io_block
// PURPOSE
//  Programmed-I/O test engine for one Aurora AXI-stream channel, slave on the io_* bus.
//  Sends a host-loaded packet of 1..TX_DEPTH words on the TX stream (single-shot or continuous loop).
//  Captures RX words in a FIFO that the host pops, and measures per-packet TX->RX latency.
//  Generalises the fixed 3-word data-pack/readback scheme.
// PARAMETERS
//  DATA_W    32  stream data width; multiple of 8, <=32
//  TX_DEPTH  8   TX packet buffer words; power of 2, 2..256
//  RX_DEPTH  16  RX capture FIFO words; power of 2, 2..256
// PORTS
//  io_clk      in   1         sole clock; io bus and stream both on it
//  reset       in   1         synchronous, active-low
//  io_sel      in   1         block selected
//  io_sync     in   1         strobe; one access committed per strobe
//  io_addr     in   16        register/buffer address
//  io_rd_en    in   1         read access
//  io_wr_en    in   1         write access
//  io_wr_data  in   32        write data
//  io_rd_data  out  32        read data, registered
//  io_rd_ack   out  1         read data valid
//  channel_up  in   1         Aurora channel up
//  tx_data     out  DATA_W    TX stream data
//  tx_tvalid   out  1         TX valid
//  tx_tready   in   1         TX ready
//  tx_tkeep    out  DATA_W/8  all ones whenever tx_tvalid is high
//  tx_tlast    out  1         last beat of the packet
//  rx_data     in   DATA_W    RX stream data
//  rx_tvalid   in   1         RX valid; no backpressure
//  rx_tlast    in   1         RX last beat
// BEHAVIOUR
//  Access timing
//   - Access commits only when io_sel & io_sync; wr commits in that cycle.
//   - Read: io_rd_data loaded in the commit cycle; io_rd_ack=1 exactly the next cycle.
//   - Unmapped read returns 0.
//  Register map (io_addr)
//   - 0x0000 CTRL W: bit0 GO (pulse), bit1 LOOP (held), bit2 RX_CLR (pulse). Read returns {30'b0,LOOP,0}.
//   - 0x0001 LEN RW: writes clamped to [1,TX_DEPTH]; reset value 1.
//   - 0x0002 STAT R: {tx_busy,tx_tready,channel_up,ovf,udf,11'b0,rx_count[15:0]}.
//   - 0x0003 RX_POP R: returns the head word zero-extended and pops it.
//     If the FIFO is empty: returns 0 and sets sticky udf.
//   - 0x0004 LAT R: last latency in cycles.
//   - 0x0005 TXPKT R: wrapping count of completed TX packets.
//   - 0x0006 RXPKT R: wrapping count of rx_tlast beats.
//   - 0x0100+i RW, i<TX_DEPTH: TX buffer word i (low DATA_W bits).
//  TX state machine
//   - IDLE: GO && channel_up -> SEND with idx=0. GO while busy or channel down is ignored.
//   - SEND: tx_tvalid=1, tx_data=buf[idx], tx_tlast=(idx==LEN-1).
//     Outputs are held stable until tx_tready.
//     Each accepted beat increments idx.
//   - On the last accepted beat: TXPKT++. Then -> GAP if LOOP, else -> IDLE.
//   - GAP: one cycle with tx_tvalid=0, then SEND with idx=0.
//     If LOOP is cleared or channel_up is low at that point -> IDLE.
//   - Clearing LOOP mid-packet finishes the current packet.
//   - channel_up drop mid-packet does not abort the current packet.
//   - Buffer and LEN writes are ignored while tx_busy (state!=IDLE).
//  RX FIFO
//   - Every rx_tvalid beat pushes rx_data.
//   - Full and no pop: word dropped, sticky ovf=1.
//   - Full with a same-cycle pop: pop then push, count unchanged, no ovf.
//   - RX_CLR empties the FIFO and clears ovf/udf. Priority: RX_CLR over push/pop in that cycle.
//  Latency
//   - Counter starts (from 0) on the first accepted beat of each packet.
//   - Counter stops on the first rx_tvalid at or after the start; LAT=count, i.e. 0 if same cycle.
//   - Counter saturates at 0xFFFF_FFFF; LAT then reads 0xFFFF_FFFF.
//   - A new packet start restarts the measurement.
//  Reset (reset==0 at posedge)
//   - All outputs 0 (tx_tkeep 0), state IDLE.
//   - FIFO empty; counters, LAT, ovf, udf, LOOP cleared; LEN=1.
//   - TX buffer contents are undefined.
//   - Reset mid-packet drops tx_tvalid the next cycle; no tlast is sent.
// TESTING
//  1. Load buf 0..2=0x11,0x22,0x33, LEN=3, GO, tready=1 -> 3 beats, tlast on beat 0x33, TXPKT=1.
//  2. tready toggles 1/0 -> data, tlast and tvalid stable while stalled; same beat order.
//  3. LEN=0 -> reads 1; LEN=300 with TX_DEPTH=8 -> reads 8.
//     LOOP=1, GO -> packets separated by one idle cycle; clear LOOP -> stops after the current tlast.
//  4. Push 17 beats into RX_DEPTH=16 -> count=16, ovf=1, first pop returns the first word.
//     Pop on empty -> 0, udf=1.
//  5. Loop TX->RX through 5-cycle delay -> LAT=5; channel_up=0 then GO -> no tvalid.
//  6. reset low mid-packet -> tvalid 0 next cycle, STAT=0 except tready/channel_up; read ack one cycle after io_sync.

Source files
------------

// File: rtl/aurora_pkt_io_block.sv
// Programmed-I/O test engine for one Aurora AXI-stream channel: host-loaded TX
// packet generator, RX capture FIFO and TX->RX latency meter behind the io_* bus.
module aurora_pkt_io_block #(
    parameter int DATA_W   = 32,
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 16
) (
    input  logic                  io_clk,
    input  logic                  reset,
    input  logic                  io_sel,
    input  logic                  io_sync,
    input  logic [15:0]           io_addr,
    input  logic                  io_rd_en,
    input  logic                  io_wr_en,
    input  logic [31:0]           io_wr_data,
    output logic [31:0]           io_rd_data,
    output logic                  io_rd_ack,
    input  logic                  channel_up,
    output logic [DATA_W-1:0]     tx_data,
    output logic                  tx_tvalid,
    input  logic                  tx_tready,
    output logic [DATA_W/8-1:0]   tx_tkeep,
    output logic                  tx_tlast,
    input  logic [DATA_W-1:0]     rx_data,
    input  logic                  rx_tvalid,
    input  logic                  rx_tlast
);
    localparam int TIW = $clog2(TX_DEPTH);
    localparam int LW  = TIW + 1;
    localparam int RIW = $clog2(RX_DEPTH);
    localparam int CW  = RIW + 1;
    localparam int KW  = DATA_W / 8;

    localparam logic [15:0]   A_CTRL    = 16'h0000;
    localparam logic [15:0]   A_LEN     = 16'h0001;
    localparam logic [15:0]   A_STAT    = 16'h0002;
    localparam logic [15:0]   A_RXPOP   = 16'h0003;
    localparam logic [15:0]   A_LAT     = 16'h0004;
    localparam logic [15:0]   A_TXPKT   = 16'h0005;
    localparam logic [15:0]   A_RXPKT   = 16'h0006;
    localparam logic [15:0]   BUF_BASE  = 16'h0100;
    localparam logic [15:0]   BUF_END   = 16'(256 + TX_DEPTH);
    localparam logic [LW-1:0] LEN_MAX   = LW'(TX_DEPTH);
    localparam logic [CW-1:0] FIFO_FULL = CW'(RX_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [TIW-1:0]  idx_q, idx_d;
    logic [LW-1:0]   len_q, len_d;
    logic            loop_q, loop_d;
    logic [31:0]     txpkt_q, txpkt_d;
    logic [31:0]     rxpkt_q, rxpkt_d;
    logic [31:0]     lat_q, lat_d;
    logic [31:0]     lat_cnt_q, lat_cnt_d;
    logic            lat_run_q, lat_run_d;
    logic [RIW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [RIW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic            ovf_q, ovf_d;
    logic            udf_q, udf_d;
    logic [31:0]     rd_data_q, rd_data_d;
    logic            rd_ack_q, rd_ack_d;

    logic [DATA_W-1:0] tx_buf [TX_DEPTH];
    logic [DATA_W-1:0] rx_mem [RX_DEPTH];

    logic           wr_s, rd_s, ctrl_wr_s, go_s, rx_clr_s, tx_busy_s;
    logic           buf_hit_s, buf_we_s;
    logic [TIW-1:0] buf_idx_s;
    logic           beat_s, last_s, start_s;
    logic           fifo_empty_s, fifo_full_s, pop_req_s, pop_s, push_s;
    logic [31:0]    rd_val_s;

    // Bus decode: one access per io_sel & io_sync strobe; buffer base is index-aligned
    always_comb begin
        wr_s      = io_sel & io_sync & io_wr_en;
        rd_s      = io_sel & io_sync & io_rd_en;
        ctrl_wr_s = wr_s & (io_addr == A_CTRL);
        go_s      = ctrl_wr_s & io_wr_data[0];
        rx_clr_s  = ctrl_wr_s & io_wr_data[2];
        tx_busy_s = (state_q != ST_IDLE);
        buf_hit_s = (io_addr >= BUF_BASE) && (io_addr < BUF_END);
        buf_idx_s = io_addr[TIW-1:0];
        buf_we_s  = wr_s & buf_hit_s & ~tx_busy_s;
    end

    // TX sequencer, LOOP/LEN registers and stream outputs
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        txpkt_d = txpkt_q;
        loop_d  = loop_q;
        len_d   = len_q;
        beat_s  = (state_q == ST_SEND) & tx_tready;
        last_s  = ({1'b0, idx_q} == (len_q - LW'(1)));

        if (ctrl_wr_s) begin
            loop_d = io_wr_data[1];
        end else begin
            loop_d = loop_q;
        end

        if (wr_s && (io_addr == A_LEN) && !tx_busy_s) begin
            if (io_wr_data == 32'd0) begin
                len_d = LW'(1);
            end else if (io_wr_data > 32'(TX_DEPTH)) begin
                len_d = LEN_MAX;
            end else begin
                len_d = io_wr_data[LW-1:0];
            end
        end else begin
            len_d = len_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (go_s && channel_up) begin
                    state_d = ST_SEND;
                    idx_d   = {TIW{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (beat_s && last_s) begin
                    txpkt_d = txpkt_q + 32'd1;
                    idx_d   = {TIW{1'b0}};
                    state_d = loop_q ? ST_GAP : ST_IDLE;
                end else if (beat_s) begin
                    idx_d = idx_q + TIW'(1);
                end else begin
                    idx_d = idx_q;
                end
            end
            ST_GAP: begin
                if (loop_q && channel_up) begin
                    state_d = ST_SEND;
                    idx_d   = {TIW{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = {TIW{1'b0}};
            end
        endcase

        tx_tvalid = (state_q == ST_SEND);
        tx_data   = tx_tvalid ? tx_buf[idx_q] : {DATA_W{1'b0}};
        tx_tlast  = tx_tvalid & last_s;
        tx_tkeep  = tx_tvalid ? {KW{1'b1}} : {KW{1'b0}};
    end

    // Latency meter: a start in the same cycle as rx_tvalid measures zero
    always_comb begin
        lat_d     = lat_q;
        lat_cnt_d = lat_cnt_q;
        lat_run_d = lat_run_q;
        start_s   = beat_s & (idx_q == {TIW{1'b0}});
        if (start_s) begin
            if (rx_tvalid) begin
                lat_d     = 32'd0;
                lat_cnt_d = 32'd0;
                lat_run_d = 1'b0;
            end else begin
                lat_cnt_d = 32'd1;
                lat_run_d = 1'b1;
            end
        end else if (lat_run_q) begin
            if (rx_tvalid) begin
                lat_d     = lat_cnt_q;
                lat_run_d = 1'b0;
            end else if (lat_cnt_q != 32'hFFFF_FFFF) begin
                lat_cnt_d = lat_cnt_q + 32'd1;
            end else begin
                lat_cnt_d = lat_cnt_q;
            end
        end else begin
            lat_d = lat_q;
        end
    end

    // RX capture FIFO; a full FIFO still accepts a push when popped in the same cycle
    always_comb begin
        fifo_empty_s = (rx_cnt_q == {CW{1'b0}});
        fifo_full_s  = (rx_cnt_q == FIFO_FULL);
        pop_req_s    = rd_s & (io_addr == A_RXPOP);
        pop_s        = pop_req_s & ~fifo_empty_s & ~rx_clr_s;
        push_s       = rx_tvalid & ~rx_clr_s & (~fifo_full_s | pop_s);
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        rx_cnt_d     = rx_cnt_q;
        ovf_d        = ovf_q;
        udf_d        = udf_q;
        rxpkt_d      = rxpkt_q + 32'(rx_tvalid & rx_tlast);

        if (rx_clr_s) begin
            wr_ptr_d = {RIW{1'b0}};
            rd_ptr_d = {RIW{1'b0}};
            rx_cnt_d = {CW{1'b0}};
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            wr_ptr_d = push_s ? (wr_ptr_q + RIW'(1)) : wr_ptr_q;
            rd_ptr_d = pop_s ? (rd_ptr_q + RIW'(1)) : rd_ptr_q;
            case ({push_s, pop_s})
                2'b10:   rx_cnt_d = rx_cnt_q + CW'(1);
                2'b01:   rx_cnt_d = rx_cnt_q - CW'(1);
                default: rx_cnt_d = rx_cnt_q;
            endcase
            ovf_d = ovf_q | (rx_tvalid & fifo_full_s & ~pop_s);
            udf_d = udf_q | (pop_req_s & fifo_empty_s);
        end
    end

    // Read-back mux and registered read response
    always_comb begin
        rd_val_s = 32'd0;
        case (io_addr)
            A_CTRL:  rd_val_s = {30'd0, loop_q, 1'b0};
            A_LEN:   rd_val_s = 32'(len_q);
            A_STAT:  rd_val_s = {tx_busy_s, tx_tready, channel_up, ovf_q, udf_q,
                                 11'd0, 16'(rx_cnt_q)};
            A_RXPOP: rd_val_s = fifo_empty_s ? 32'd0 : 32'(rx_mem[rd_ptr_q]);
            A_LAT:   rd_val_s = lat_q;
            A_TXPKT: rd_val_s = txpkt_q;
            A_RXPKT: rd_val_s = rxpkt_q;
            default: begin
                if (buf_hit_s) begin
                    rd_val_s = 32'(tx_buf[buf_idx_s]);
                end else begin
                    rd_val_s = 32'd0;
                end
            end
        endcase
        rd_ack_d  = rd_s;
        rd_data_d = rd_s ? rd_val_s : rd_data_q;
    end

    assign io_rd_data = rd_data_q;
    assign io_rd_ack  = rd_ack_q;

    // Control and status state with synchronous active-low reset
    always_ff @(posedge io_clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= {TIW{1'b0}};
            len_q     <= LW'(1);
            loop_q    <= 1'b0;
            txpkt_q   <= 32'd0;
            rxpkt_q   <= 32'd0;
            lat_q     <= 32'd0;
            lat_cnt_q <= 32'd0;
            lat_run_q <= 1'b0;
            wr_ptr_q  <= {RIW{1'b0}};
            rd_ptr_q  <= {RIW{1'b0}};
            rx_cnt_q  <= {CW{1'b0}};
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            rd_data_q <= 32'd0;
            rd_ack_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            loop_q    <= loop_d;
            txpkt_q   <= txpkt_d;
            rxpkt_q   <= rxpkt_d;
            lat_q     <= lat_d;
            lat_cnt_q <= lat_cnt_d;
            lat_run_q <= lat_run_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rx_cnt_q  <= rx_cnt_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
            rd_data_q <= rd_data_d;
            rd_ack_q  <= rd_ack_d;
        end
    end

    // Packet buffer and FIFO storage carry no reset
    always_ff @(posedge io_clk) begin
        if (buf_we_s) begin
            tx_buf[buf_idx_s] <= io_wr_data[DATA_W-1:0];
        end
        if (push_s) begin
            rx_mem[wr_ptr_q] <= rx_data;
        end
    end

endmodule
